regfile_param_dump: RTL and testbench

- Parametrised successor to the CPU register file: configurable data width and depth, with register 0 hardwired to zero.
- Provides write-through bypass on both read ports; a matching read returns the incoming data instead of high-Z.
- Adds a sequential dump engine that streams a contiguous register range over a valid/ready interface. This replaces hard-wired per-register exposure ports for the plotter controller and debug path.
- Per-register dirty tracking shows which registers changed since they were last dumped.

---
 rtl/regfile_param_dump.sv | 170 +++++++++++++++++
 tb/tb_regfile_param_dump.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_dump.sv
// Parametrised register file with write-through bypass on both read ports,
// a valid/ready dump engine that streams a contiguous (wrapping) index range,
// and per-register dirty tracking cleared as registers are dumped.
module regfile_param_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic                       ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]      ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]      data_writeReg,
    input  logic [ADDR_WIDTH-1:0]      ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]      ctrl_readRegB,
    output logic [DATA_WIDTH-1:0]      data_readRegA,
    output logic [DATA_WIDTH-1:0]      data_readRegB,
    input  logic                       dump_start,
    input  logic [ADDR_WIDTH-1:0]      dump_first,
    input  logic [ADDR_WIDTH-1:0]      dump_last,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [ADDR_WIDTH-1:0]      dump_addr,
    output logic [DATA_WIDTH-1:0]      dump_data,
    output logic                       dump_busy,
    output logic                       dump_done,
    output logic [(2**ADDR_WIDTH)-1:0] dirty_mask
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DEPTH-1:0]      dirty_q, dirty_d;

    logic                  writeHit;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] peekIdx;
    logic [DATA_WIDTH-1:0] peekData;

    // Register 0 reads as zero; a same-cycle write to the index wins over storage.
    function automatic logic [DATA_WIDTH-1:0] readBypass(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] value;
        value = regs_q[idx];
        if (idx == '0) begin
            value = '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == idx)) begin
            value = data_writeReg;
        end
        return value;
    endfunction

    assign writeHit  = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign handshake = valid_q && dump_ready;

    // The dump engine looks at dump_first when starting, otherwise the next index.
    assign peekIdx = (state_q == IDLE) ? dump_first : (addr_q + ADDR_WIDTH'(1));

    // Combinational read ports and the value the next dump beat would capture.
    always_comb begin
        data_readRegA = readBypass(ctrl_readRegA);
        data_readRegB = readBypass(ctrl_readRegB);
        peekData      = readBypass(peekIdx);
    end

    // Register storage; index 0 is never written so it stays zero.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeHit) begin
            regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Dump sequencing: capture a beat on start, advance on each accepted beat.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    last_d  = dump_last;
                    addr_d  = dump_first;
                    data_d  = peekData;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (addr_q == last_q) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        addr_d = peekIdx;
                        data_d = peekData;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Dump engine state; reset aborts any dump in flight without a done pulse.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // A write in the same cycle as the beat's handshake keeps the bit set.
    always_comb begin
        dirty_d = dirty_q;
        if (handshake) begin
            dirty_d[addr_q] = 1'b0;
        end
        if (writeHit) begin
            dirty_d[ctrl_writeReg] = 1'b1;
        end
        dirty_d[0] = 1'b0;
    end

    // Dirty mask register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;
    assign dump_busy  = (state_q != IDLE);
    assign dump_done  = (state_q == DONE);
    assign dirty_mask = dirty_q;

endmodule

// File: tb/tb_regfile_param_dump.sv
// Directed bench for regfile_param_dump: reads, bypass, dumps, stalls, wrap, reset abort.
module tb_regfile_param_dump;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        dump_start;
    logic [4:0]  dump_first;
    logic [4:0]  dump_last;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;
    logic [31:0] dirty_mask;

    int vectors;
    int miscompares;

    regfile_param_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .dump_start      (dump_start),
        .dump_first      (dump_first),
        .dump_last       (dump_last),
        .dump_valid      (dump_valid),
        .dump_ready      (dump_ready),
        .dump_addr       (dump_addr),
        .dump_data       (dump_data),
        .dump_busy       (dump_busy),
        .dump_done       (dump_done),
        .dirty_mask      (dirty_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write one register over a single rising edge; returns on the next falling edge.
    task automatic doWrite(input logic [4:0] idx, input logic [31:0] val);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = idx;
        data_writeReg    = val;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            vectors++;
            if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_read idx=%0d: A=%h B=%h expected 0", i, data_readRegA, data_readRegB);
            end
        end
        vectors++;
        if (dirty_mask !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dirty: got %h expected 0", dirty_mask);
        end
        vectors++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dump: v/b/d=%b addr=%0d data=%h expected 000/0/0",
                     {dump_valid, dump_busy, dump_done}, dump_addr, dump_data);
        end
        @(negedge clock);
    endtask

    task automatic test_write_bypass();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd6;
        #1;
        vectors++;
        if (data_readRegA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL bypass_A: got %h expected deadbeef", data_readRegA);
        end
        vectors++;
        if (data_readRegB !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL bypass_other: got %h expected 0", data_readRegB);
        end
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        #1;
        vectors++;
        if (data_readRegA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL stored_r5: got %h expected deadbeef", data_readRegA);
        end
        vectors++;
        if (dirty_mask !== 32'h0000_0020) begin
            miscompares++;
            $display("[TB] FAIL dirty_r5: got %h expected 00000020", dirty_mask);
        end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h1234;
        ctrl_readRegB    = 5'd0;
        #1;
        vectors++;
        if (data_readRegB !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL r0_bypass: got %h expected 0", data_readRegB);
        end
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        #1;
        vectors++;
        if (data_readRegB !== 32'h0 || dirty_mask !== 32'h0000_0020) begin
            miscompares++;
            $display("[TB] FAIL r0_write: B=%h dirty=%h expected 0 / 00000020", data_readRegB, dirty_mask);
        end
    endtask

    task automatic test_dump_basic();
        doWrite(5'd1, 32'd1);
        doWrite(5'd2, 32'd2);
        doWrite(5'd3, 32'd3);
        dump_first = 5'd1;
        dump_last  = 5'd3;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            vectors++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'(b + 1) || dump_data !== 32'(b + 1) || dump_done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL basic_beat%0d: v=%b addr=%0d data=%h done=%b expected 1/%0d/%0d/0",
                         b, dump_valid, dump_addr, dump_data, dump_done, b + 1, b + 1);
            end
            @(negedge clock);
        end
        vectors++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_done: done=%b valid=%b busy=%b expected 1/0/1", dump_done, dump_valid, dump_busy);
        end
        @(negedge clock);
        vectors++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_idle: done=%b busy=%b expected 0/0", dump_done, dump_busy);
        end
        vectors++;
        if (dirty_mask !== 32'h0000_0020) begin
            miscompares++;
            $display("[TB] FAIL basic_dirty: got %h expected 00000020", dirty_mask);
        end
    endtask

    task automatic test_stall();
        dump_first = 5'd1;
        dump_last  = 5'd3;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
        vectors++;
        if (dump_addr !== 5'd1 || dump_data !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL stall_beat1: addr=%0d data=%h expected 1/1", dump_addr, dump_data);
        end
        @(negedge clock);
        dump_ready       = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd2;
        data_writeReg    = 32'h99;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'd2 || dump_data !== 32'd2) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: v=%b addr=%0d data=%h expected 1/2/2",
                         k, dump_valid, dump_addr, dump_data);
            end
        end
        vectors++;
        if (dirty_mask[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_dirty_during: got %b expected 1", dirty_mask[2]);
        end
        dump_ready = 1'b1;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        vectors++;
        if (dump_addr !== 5'd3 || dump_data !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL stall_beat3: addr=%0d data=%h expected 3/3", dump_addr, dump_data);
        end
        @(negedge clock);
        vectors++;
        if (dump_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_done: got %b expected 1", dump_done);
        end
        @(negedge clock);
        ctrl_readRegA = 5'd2;
        #1;
        vectors++;
        if (dirty_mask !== 32'h0000_0024) begin
            miscompares++;
            $display("[TB] FAIL stall_dirty_after: got %h expected 00000024", dirty_mask);
        end
        vectors++;
        if (data_readRegA !== 32'h99) begin
            miscompares++;
            $display("[TB] FAIL stall_r2: got %h expected 99", data_readRegA);
        end
    endtask

    task automatic test_wrap();
        logic [4:0]  expAddr [4];
        logic [31:0] expData [4];
        expAddr = '{5'd30, 5'd31, 5'd0, 5'd1};
        expData = '{32'h30, 32'h31, 32'h0, 32'h11};
        doWrite(5'd30, 32'h30);
        doWrite(5'd31, 32'h31);
        doWrite(5'd1, 32'h11);
        dump_first = 5'd30;
        dump_last  = 5'd1;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if (dump_valid !== 1'b1 || dump_addr !== expAddr[b] || dump_data !== expData[b]) begin
                miscompares++;
                $display("[TB] FAIL wrap_beat%0d: v=%b addr=%0d data=%h expected 1/%0d/%h",
                         b, dump_valid, dump_addr, dump_data, expAddr[b], expData[b]);
            end
            dump_start = (b == 1);
            dump_first = 5'd5;
            dump_last  = 5'd5;
            @(negedge clock);
        end
        dump_start = 1'b0;
        vectors++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_done: done=%b valid=%b expected 1/0", dump_done, dump_valid);
        end
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_no_queue: busy=%b valid=%b expected 0/0", dump_busy, dump_valid);
        end
        vectors++;
        if (dirty_mask !== 32'h0000_0024) begin
            miscompares++;
            $display("[TB] FAIL wrap_dirty: got %h expected 00000024", dirty_mask);
        end
    endtask

    task automatic test_reset_mid_dump();
        doWrite(5'd11, 32'hAB);
        dump_first = 5'd10;
        dump_last  = 5'd17;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
        vectors++;
        if (dump_addr !== 5'd10 || dump_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_beat1: addr=%0d data=%h expected 10/0", dump_addr, dump_data);
        end
        @(negedge clock);
        vectors++;
        if (dump_addr !== 5'd11 || dump_data !== 32'hAB) begin
            miscompares++;
            $display("[TB] FAIL abort_beat2: addr=%0d data=%h expected 11/ab", dump_addr, dump_data);
        end
        ctrl_reset    = 1'b1;
        ctrl_readRegA = 5'd11;
        ctrl_readRegB = 5'd5;
        #1;
        vectors++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: v/b/d=%b addr=%0d data=%h expected 000/0/0",
                     {dump_valid, dump_busy, dump_done}, dump_addr, dump_data);
        end
        vectors++;
        if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0 || dirty_mask !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_regs: A=%h B=%h dirty=%h expected 0/0/0", data_readRegA, data_readRegB, dirty_mask);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: done=%b busy=%b valid=%b expected 0/0/0", dump_done, dump_busy, dump_valid);
        end
        doWrite(5'd4, 32'd4);
        dump_first = 5'd4;
        dump_last  = 5'd4;
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
        vectors++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd4 || dump_data !== 32'd4 || dirty_mask !== 32'h0000_0010) begin
            miscompares++;
            $display("[TB] FAIL single_beat: v=%b addr=%0d data=%h dirty=%h expected 1/4/4/00000010",
                     dump_valid, dump_addr, dump_data, dirty_mask);
        end
        @(negedge clock);
        vectors++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dirty_mask !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL single_done: done=%b valid=%b dirty=%h expected 1/0/0", dump_done, dump_valid, dirty_mask);
        end
        @(negedge clock);
        vectors++;
        if (dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: busy=%b done=%b expected 0/0", dump_busy, dump_done);
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;
        dump_start       = 1'b0;
        dump_first       = '0;
        dump_last        = '0;
        dump_ready       = 1'b0;
        test_reset();
        test_write_bypass();
        test_dump_basic();
        test_stall();
        test_wrap();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
